// File: rtl/gate_sweep_tester_pkg.sv
// Shared definitions for the gate sweep tester: FSM states and truth tables for common gates.
// Truth tables are indexed by {a,b}: bit0 = 00, bit1 = 01, bit2 = 10, bit3 = 11.
package gate_sweep_tester_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int CNT_W = 16;

    localparam logic [1:0] VEC_LAST = 2'd3;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_sweep_tester_if.sv
// Tester <-> gate-under-test / environment bundle: sweep control, gate pins and results.
// master = the tester, slave = the gate plus whoever starts sweeps and reads results.
interface gate_sweep_tester_if;
    import gate_sweep_tester_pkg::*;

    logic       start;
    logic       y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        output start, y,
        input  a, b, busy, done, pass, err_cnt, fail_vec
    );

endinterface

// File: rtl/gate_sweep_tester_hold_timer.sv
// Hold-window counter: expire is high while count == HOLD_CYCLES-1; wraps to 0 there when enabled.
// No latency beyond the register; no backpressure, clr has priority over en.
module gate_hold_timer
    import gate_sweep_tester_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expire ? '0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/gate_sweep_tester.sv
// Drives a 2-input gate through 00/01/10/11 for HOLD_CYCLES each, checks y against TRUTH; done 4*HOLD_CYCLES edges after start.
// No backpressure: start is only honoured in IDLE/DONE and ignored while a sweep runs.
module gate_sweep_tester
    import gate_sweep_tester_pkg::*;
#(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [3:0] TRUTH       = TT_XNOR
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_sweep_tester_if.master io
);

    state_t     state;
    logic [1:0] vec;
    logic       expire;
    logic       tmr_en;
    logic       tmr_clr;
    logic       mismatch;
    logic [2:0] err_nxt;

    // Timer is held cleared outside DRIVE so every sweep starts its first window at 0.
    assign tmr_en   = (state == S_DRIVE);
    assign tmr_clr  = !tmr_en;
    assign mismatch = (io.y != TRUTH[vec]);
    assign err_nxt  = io.err_cnt + {2'b00, mismatch};

    gate_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            vec         <= 2'd0;
            io.a        <= 1'b0;
            io.b        <= 1'b0;
            io.busy     <= 1'b0;
            io.done     <= 1'b0;
            io.pass     <= 1'b0;
            io.err_cnt  <= 3'd0;
            io.fail_vec <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (io.start) begin
                        state       <= S_DRIVE;
                        vec         <= 2'd0;
                        io.a        <= 1'b0;
                        io.b        <= 1'b0;
                        io.busy     <= 1'b1;
                        io.done     <= 1'b0;
                        io.pass     <= 1'b0;
                        io.err_cnt  <= 3'd0;
                        io.fail_vec <= 4'd0;
                    end
                end
                S_DRIVE: begin
                    if (expire) begin
                        if (mismatch) begin
                            io.fail_vec[vec] <= 1'b1;
                            io.err_cnt       <= err_nxt;
                        end
                        if (vec != VEC_LAST) begin
                            vec              <= vec + 2'd1;
                            {io.a, io.b}     <= vec + 2'd1;
                        end else begin
                            // err_nxt already folds in the last vector's compare.
                            state   <= S_DONE;
                            vec     <= 2'd0;
                            io.a    <= 1'b0;
                            io.b    <= 1'b0;
                            io.busy <= 1'b0;
                            io.done <= 1'b1;
                            io.pass <= (err_nxt == 3'd0);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_tester.sv
// Scoreboarded bench: three tester instances with different hold lengths and truth tables,
// each driving a bench-modelled gate whose truth table is chosen per sweep.
module tb_gate_sweep_tester;
    import gate_sweep_tester_pkg::*;

    localparam int NDUT = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] gtt [NDUT];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    gate_sweep_tester_if if0 ();
    gate_sweep_tester_if if1 ();
    gate_sweep_tester_if if2 ();

    assign if0.y = gtt[0][{if0.a, if0.b}];
    assign if1.y = gtt[1][{if1.a, if1.b}];
    assign if2.y = gtt[2][{if2.a, if2.b}];

    gate_sweep_tester #(.HOLD_CYCLES(10), .TRUTH(TT_XNOR)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
    gate_sweep_tester #(.HOLD_CYCLES(1),  .TRUTH(TT_XNOR)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1));
    gate_sweep_tester #(.HOLD_CYCLES(3),  .TRUTH(TT_NAND)) dut2 (.clk(clk), .rst_n(rst_n), .io(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        int         k;
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
    } exp_t;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
    } obs_t;

    exp_t exp_q[$];

    function automatic int hold_of(input int id);
        case (id)
            0:       return 10;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] truth_of(input int id);
        case (id)
            0:       return TT_XNOR;
            1:       return TT_XNOR;
            default: return TT_NAND;
        endcase
    endfunction

    function automatic obs_t get_obs(input int id);
        obs_t o;
        case (id)
            0:       o = '{if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_cnt, if0.fail_vec};
            1:       o = '{if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.err_cnt, if1.fail_vec};
            default: o = '{if2.a, if2.b, if2.busy, if2.done, if2.pass, if2.err_cnt, if2.fail_vec};
        endcase
        return o;
    endfunction

    // Expected result: for every input vector, does the attached gate disagree with the truth table?
    function automatic exp_t model(input int id, input int k, input logic [3:0] gate);
        exp_t       e;
        int         n = 0;
        logic [3:0] want = truth_of(id);
        e.id = id;
        e.k  = k;
        e.fv = 4'd0;
        for (int v = 0; v < 4; v++) begin
            if (want[v] != gate[v]) begin
                e.fv[v] = 1'b1;
                n++;
            end
        end
        e.err  = 3'(n);
        e.pass = (n == 0);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: records the {a,b} trace while busy and scores each completed sweep.
    logic       prev_done [NDUT];
    logic       prev_busy [NDUT];
    int         tlen      [NDUT];
    logic [1:0] trace     [NDUT][128];

    task automatic mon_step(input int id, input obs_t o);
        int   idx;
        int   h;
        int   bad;
        exp_t e;
        if (!rst_n) begin
            prev_done[id] = 1'b0;
            prev_busy[id] = 1'b0;
            tlen[id]      = 0;
            return;
        end
        if (o.busy && !prev_busy[id]) tlen[id] = 0;
        if (o.busy) begin
            if (tlen[id] < 128) trace[id][tlen[id]] = {o.a, o.b};
            tlen[id]++;
        end
        if (o.done && !prev_done[id]) begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].id == id) begin
                    idx = i;
                    break;
                end
            end
            if (idx < 0) begin
                check($sformatf("dut%0d_unexpected_done", id), 1, 0);
            end else begin
                e = exp_q[idx];
                exp_q.delete(idx);
                h = hold_of(id);
                check($sformatf("dut%0d_done_latency", id), cyc - e.k, 4 * h);
                check($sformatf("dut%0d_pass", id), int'(o.pass), int'(e.pass));
                check($sformatf("dut%0d_err_cnt", id), int'(o.err), int'(e.err));
                check($sformatf("dut%0d_fail_vec", id), int'(o.fv), int'(e.fv));
                check($sformatf("dut%0d_done_idle_pins", id), int'({o.a, o.b, o.busy}), 0);
                bad = (tlen[id] != 4 * h) ? 1 : 0;
                for (int j = 0; j < tlen[id] && j < 128 && bad == 0; j++)
                    if (int'(trace[id][j]) != j / h) bad = 1;
                check($sformatf("dut%0d_ab_sequence", id), bad, 0);
            end
        end
        prev_done[id] = o.done;
        prev_busy[id] = o.busy;
    endtask

    always @(negedge clk) begin
        for (int id = 0; id < NDUT; id++) mon_step(id, get_obs(id));
    end

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       if0.start = v;
            1:       if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    task automatic wait_done(input int id);
        int   n = 0;
        obs_t o;
        do begin
            @(negedge clk);
            n++;
            o = get_obs(id);
        end while (!o.done && n < 4 * hold_of(id) + 20);
        if (!o.done) check($sformatf("dut%0d_done_timeout", id), 0, 1);
    endtask

    task automatic sweep(input int id, input logic [3:0] gate);
        @(negedge clk);
        gtt[id] = gate;
        set_start(id, 1'b1);
        exp_q.push_back(model(id, cyc + 1, gate));
        @(negedge clk);
        set_start(id, 1'b0);
        wait_done(id);
    endtask

    initial begin
        obs_t o;
        int   k;
        int   id;
        rst_n = 1'b0;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        for (int i = 0; i < NDUT; i++) gtt[i] = TT_XNOR;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("dut%0d_reset_state", i), int'(get_obs(i)), 0);
        rst_n = 1'b1;

        // Correct gate, wrong gate, stuck-at-1 gate.
        sweep(0, TT_XNOR);
        sweep(0, TT_XOR);
        sweep(0, 4'b1111);

        // Restart from DONE clears results on the accepting edge; a start mid-sweep is ignored.
        @(negedge clk);
        gtt[0] = TT_XNOR;
        if0.start = 1'b1;
        exp_q.push_back(model(0, cyc + 1, TT_XNOR));
        @(negedge clk);
        if0.start = 1'b0;
        o = get_obs(0);
        check("restart_done_drops", int'(o.done), 0);
        check("restart_busy", int'(o.busy), 1);
        check("restart_results_clear", int'({o.pass, o.err, o.fv}), 0);
        repeat (14) @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        wait_done(0);

        // Asynchronous reset partway through a failing sweep.
        @(negedge clk);
        gtt[0] = TT_XOR;
        if0.start = 1'b1;
        exp_q.push_back(model(0, cyc + 1, TT_XOR));
        @(negedge clk);
        if0.start = 1'b0;
        repeat (24) @(negedge clk);
        check("pre_reset_err_cnt", int'(if0.err_cnt), 2);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'(get_obs(0)), 0);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].id == 0) exp_q.delete(i);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sweep(0, TT_XNOR);

        // start held high: a new sweep begins on the first DONE cycle, so done lasts one cycle.
        @(negedge clk);
        gtt[0] = TT_NOR;
        if0.start = 1'b1;
        k = cyc + 1;
        exp_q.push_back(model(0, k, TT_NOR));
        exp_q.push_back(model(0, k + 41, TT_NOR));
        wait_done(0);
        @(negedge clk);
        o = get_obs(0);
        check("held_start_done_one_cycle", int'({o.done, o.busy}), 1);
        if0.start = 1'b0;
        wait_done(0);

        // HOLD_CYCLES=1 instance and the NAND-table instance.
        sweep(1, TT_XNOR);
        sweep(1, TT_AND);
        sweep(2, TT_NAND);
        sweep(2, TT_OR);

        for (int r = 0; r < 10; r++) begin
            id = $urandom_range(0, NDUT - 1);
            sweep(id, 4'($urandom_range(0, 15)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
